// File: rtl/udc_pkg.sv
// udc_pkg: shared constants and types for the up/down counter slice.
// Register map, data width, sequencer states and bus-op encoding.
package udc_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  localparam logic [1:0] ADDR_PLR = 2'b00;
  localparam logic [1:0] ADDR_ULR = 2'b01;
  localparam logic [1:0] ADDR_LLR = 2'b10;
  localparam logic [1:0] ADDR_CCR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CHK,
    S_START,
    S_WAIT_EC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD,
    OP_STB
  } bus_op_t;

endpackage

// File: rtl/udc_config_sequencer_bus_if.sv
// udc_bus_if: registers one bus cycle per clock from an op request.
// Reads span two requests; rd_done marks the end of the second one.
module udc_bus_if
  import udc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  bus_op_t    op,
  input  logic [1:0] addr,
  input  data_t      wdata,
  input  logic       last,
  input  data_t      din_in,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a1,
  output logic       a0,
  output data_t      din_out,
  output logic       din_oe,
  output data_t      rdata,
  output logic       rd_done
);

  logic rd_last_q;

  // Strobes and address follow the request one clock later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ncs       <= 1'b1;
      nwr       <= 1'b1;
      nrd       <= 1'b1;
      a1        <= 1'b0;
      a0        <= 1'b0;
      din_out   <= '0;
      din_oe    <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      ncs       <= (op == OP_NONE);
      nwr       <= (op != OP_WR);
      nrd       <= (op != OP_RD);
      {a1, a0}  <= addr;
      din_out   <= (op == OP_WR) ? wdata : '0;
      din_oe    <= (op == OP_WR);
      rd_last_q <= (op == OP_RD) && last;
    end
  end

  assign rdata   = din_in;
  assign rd_done = rd_last_q;

endmodule

// File: rtl/udc_config_sequencer.sv
// udc_config_sequencer: programs the counter registers, optionally
// reads them back, starts a run and reports its outcome.
module udc_config_sequencer
  import udc_pkg::*;
#(
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT_W    = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cfg_valid,
  output logic  cfg_ready,
  input  data_t cfg_plr,
  input  data_t cfg_ulr,
  input  data_t cfg_llr,
  input  data_t cfg_ccr,
  input  logic  cfg_verify,
  output logic  ncs,
  output logic  nwr,
  output logic  nrd,
  output logic  a1,
  output logic  a0,
  output data_t din_out,
  output logic  din_oe,
  input  data_t din_in,
  output logic  start,
  input  logic  ec,
  input  logic  err,
  output logic  done,
  output logic  st_range,
  output logic  st_verify,
  output logic  st_timeout
);

  localparam logic SC_LAST = 1'(START_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE =
    {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  logic [2:0]           cnt;
  logic                 sc_cnt;
  logic [TIMEOUT_W-1:0] wdog;
  data_t                regs_q [4];
  logic                 verify_q;

  bus_op_t    req_op;
  logic [1:0] req_addr;
  logic       req_last;
  data_t      rdata;
  logic       rd_done;
  logic       take;
  logic       rd_bad;
  logic       range_bad;

  assign take      = cfg_valid & cfg_ready;
  assign rd_bad    = rd_done & (rdata != regs_q[{a1, a0}]);
  assign range_bad = (regs_q[ADDR_PLR] < regs_q[ADDR_LLR])
                   | (regs_q[ADDR_PLR] > regs_q[ADDR_ULR])
                   | err;

  // Bus request derived from the current state.
  always_comb begin
    req_op   = OP_NONE;
    req_addr = 2'b00;
    req_last = 1'b0;
    unique case (1'b1)
      state == S_WR: begin
        req_op   = OP_WR;
        req_addr = cnt[1:0];
      end
      state == S_RD: begin
        req_op   = OP_RD;
        req_addr = cnt[2:1];
        req_last = cnt[0];
      end
      state == S_START: req_op = OP_STB;
      default: ;
    endcase
  end

  udc_bus_if u_bus (
    .clk     (clk),
    .reset   (reset),
    .op      (req_op),
    .addr    (req_addr),
    .wdata   (regs_q[req_addr]),
    .last    (req_last),
    .din_in  (din_in),
    .ncs     (ncs),
    .nwr     (nwr),
    .nrd     (nrd),
    .a1      (a1),
    .a0      (a0),
    .din_out (din_out),
    .din_oe  (din_oe),
    .rdata   (rdata),
    .rd_done (rd_done)
  );

  // Job sequencing, handshake, start/done strobes and status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sc_cnt     <= 1'b0;
      wdog       <= '0;
      verify_q   <= 1'b0;
      cfg_ready  <= 1'b0;
      start      <= 1'b0;
      done       <= 1'b0;
      st_range   <= 1'b0;
      st_verify  <= 1'b0;
      st_timeout <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      cfg_ready <= (state == S_IDLE) && !take;
      start     <= (state == S_START);
      done      <= (state == S_DONE);
      if (rd_bad) st_verify <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (take) begin
            regs_q[ADDR_PLR] <= cfg_plr;
            regs_q[ADDR_ULR] <= cfg_ulr;
            regs_q[ADDR_LLR] <= cfg_llr;
            regs_q[ADDR_CCR] <= cfg_ccr;
            verify_q   <= cfg_verify;
            st_range   <= 1'b0;
            st_verify  <= 1'b0;
            st_timeout <= 1'b0;
            cnt        <= '0;
            state      <= S_WR;
          end
        end
        S_WR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            cnt   <= '0;
            state <= verify_q ? S_RD : S_CHK;
          end
        end
        S_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= S_CHK;
        end
        S_CHK: begin
          st_range <= range_bad;
          sc_cnt   <= 1'b0;
          if (range_bad || st_verify || rd_bad ||
              regs_q[ADDR_CCR] == '0)
            state <= S_DONE;
          else
            state <= S_START;
        end
        S_START: begin
          sc_cnt <= sc_cnt + 1'b1;
          if (sc_cnt == SC_LAST) begin
            wdog  <= '0;
            state <= S_WAIT_EC;
          end
        end
        S_WAIT_EC: begin
          if (ec) begin
            state <= S_DONE;
          end else begin
            wdog <= wdog + WD_ONE;
            if (wdog == WD_LAST) begin
              st_timeout <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udc_config_sequencer.sv
// tb_udc_config_sequencer: directed jobs with a bus-event scoreboard.
// Expected bus/start/done events are queued per job and popped on sight.
module tb_udc_config_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_plr = '0, cfg_ulr = '0, cfg_llr = '0, cfg_ccr = '0;
  logic       cfg_verify = 1'b0;
  logic       ncs, nwr, nrd, a1, a0;
  logic [7:0] din_out;
  logic       din_oe;
  logic [7:0] din_in;
  logic       start;
  logic       ec = 1'b0;
  logic       err = 1'b0;
  logic       done, st_range, st_verify, st_timeout;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;

  logic [7:0] mem [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic       corrupt = 1'b0;

  typedef struct packed {
    logic [1:0]  k;
    logic [1:0]  a;
    logic [7:0]  d;
    logic        oe;
    logic [2:0]  st;
    logic [31:0] cyc;
  } ev_t;

  ev_t q[$];

  udc_config_sequencer #(.START_CYCLES(1), .TIMEOUT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_plr    (cfg_plr),
    .cfg_ulr    (cfg_ulr),
    .cfg_llr    (cfg_llr),
    .cfg_ccr    (cfg_ccr),
    .cfg_verify (cfg_verify),
    .ncs        (ncs),
    .nwr        (nwr),
    .nrd        (nrd),
    .a1         (a1),
    .a0         (a0),
    .din_out    (din_out),
    .din_oe     (din_oe),
    .din_in     (din_in),
    .start      (start),
    .ec         (ec),
    .err        (err),
    .done       (done),
    .st_range   (st_range),
    .st_verify  (st_verify),
    .st_timeout (st_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter register model answering reads, with optional ULR corruption.
  assign din_in = (corrupt && {a1, a0} == 2'b01) ? 8'd14 : mem[{a1, a0}];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [1:0] a,
                               input logic [7:0] d, input logic oe,
                               input logic [2:0] st, input int c);
    ev_t e;
    e.k = k; e.a = a; e.d = d; e.oe = oe; e.st = st; e.cyc = 32'(c);
    q.push_back(e);
  endfunction

  task automatic see(input logic [1:0] k, input logic [1:0] a,
                     input logic [7:0] d, input logic oe,
                     input logic [2:0] st);
    ev_t o;
    ev_t e;
    o.k = k; o.a = a; o.d = d; o.oe = oe; o.st = st; o.cyc = 32'(cyc);
    if (q.size() == 0) begin
      nvec++;
      assert (q.size() != 0) else begin
        nmis++;
        $error("FAIL unexpected_event observed=%h expected=none", o);
      end
    end else begin
      e = q.pop_front();
      chk("bus_event", 64'(o), 64'(e));
    end
  endtask

  // Monitor: classify each cycle's DUT activity into scoreboard events.
  always @(negedge clk) begin
    if (!ncs && !nwr) begin
      mem[{a1, a0}] = din_out;
      see(2'd0, {a1, a0}, din_out, din_oe, 3'b000);
    end else if (!ncs && !nrd) begin
      see(2'd1, {a1, a0}, din_in, din_oe, 3'b000);
    end
    if (start) see(2'd2, 2'b00, 8'h00, 1'b0, 3'b000);
    if (done) see(2'd3, 2'b00, 8'h00, 1'b0,
                  {st_range, st_verify, st_timeout});
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
    chk("ready_wait", 64'(cfg_ready), 64'd1);
  endtask

  task automatic job(input logic [7:0] p, u, l, c,
                     input bit ver, cor, er, input int ecd,
                     input bit ec_st, input bit poke);
    logic [7:0] v [4];
    int t, s, d;
    bit rng, vf, abort;
    v[0] = p; v[1] = u; v[2] = l; v[3] = c;
    wait_ready();
    cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c;
    cfg_verify = ver; err = er; corrupt = cor; cfg_valid = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 4; k++)
      push(2'd0, 2'(k), v[k], 1'b1, 3'b000, t + 1 + k);
    if (ver)
      for (int i = 0; i < 8; i++)
        push(2'd1, 2'(i / 2), (cor && i / 2 == 1) ? 8'd14 : v[i / 2],
             1'b0, 3'b000, t + 5 + i);
    s = t + 6 + (ver ? 8 : 0);
    rng = (p < l) || (p > u) || er;
    vf = ver && cor;
    abort = rng || vf || (c == 8'd0);
    if (abort) begin
      d = s;
    end else begin
      push(2'd2, 2'b00, 8'h00, 1'b0, 3'b000, s);
      d = (ecd < 0) ? s + 16 : s + ecd + 2;
    end
    push(2'd3, 2'b00, 8'h00, 1'b0, {rng, vf, !abort && ecd < 0}, d);
    @(negedge clk);
    if (poke) begin
      cfg_plr = 8'h55; cfg_ulr = 8'h66; cfg_llr = 8'h77; cfg_ccr = 8'h00;
      repeat (3) @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (ec_st) begin
      wait_cyc(s - 1); ec = 1'b1;
      wait_cyc(s); ec = 1'b0;
    end
    if (!abort && ecd >= 0) begin
      wait_cyc(s + ecd); ec = 1'b1;
      wait_cyc(s + ecd + 1); ec = 1'b0;
    end
    wait_cyc(d);
    chk("ready_at_done", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_done", 64'(cfg_ready), 64'd1);
    chk("queue_drained", 64'(q.size()), 64'd0);
    err = 1'b0;
    corrupt = 1'b0;
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({ncs, nwr, nrd, a1, a0, din_out, din_oe, start, done,
             st_range, st_verify, st_timeout, cfg_ready}),
        64'({3'b111, 17'b0}));
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(cfg_ready), 64'd1);

    job(8'd10, 8'd15, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    job(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    job(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    job(8'd20, 8'd15, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    job(8'd10, 8'd15, 8'd5, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    job(8'd3, 8'd15, 8'd5, 8'd4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    job(8'd10, 8'd15, 8'd5, 8'd2, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    job(8'd5, 8'd5, 8'd5, 8'd1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    job(8'd255, 8'd255, 8'd0, 8'd9, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    job(8'd7, 8'd9, 8'd1, 8'd3, 1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0);

    // Reset while the ULR readback is on the bus.
    wait_ready();
    cfg_plr = 8'd10; cfg_ulr = 8'd15; cfg_llr = 8'd5; cfg_ccr = 8'd2;
    cfg_verify = 1'b1; cfg_valid = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 4; k++)
      push(2'd0, 2'(k), (k == 0) ? 8'd10 : (k == 1) ? 8'd15 :
           (k == 2) ? 8'd5 : 8'd2, 1'b1, 3'b000, t + 1 + k);
    push(2'd1, 2'b00, 8'd10, 1'b0, 3'b000, t + 5);
    push(2'd1, 2'b00, 8'd10, 1'b0, 3'b000, t + 6);
    push(2'd1, 2'b01, 8'd15, 1'b0, 3'b000, t + 7);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_cyc(t + 7);
    #1;
    chk("queue_before_reset", 64'(q.size()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("bus_after_reset",
        64'({ncs, nwr, nrd, din_oe, start, done, cfg_ready}),
        64'(7'b1110000));
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_midjob_reset", 64'(cfg_ready), 64'd1);
    repeat (20) @(negedge clk);

    job(8'd10, 8'd15, 8'd5, 8'd2, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
